// File: rtl/peak_rv32im_alu_arb.sv
`timescale 1ns/1ps
// peak_rv32im_alu_arb
//   Shares one external combinational RV32IM ALU between NREQ requesters.
//   Round-robin grant into an operand stage (S1) that drives the ALU; the
//   ALU result is captured into a response stage (S2) with the winner ID,
//   the request tag and an error flag.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous kill of S1/S2, blocks accept this cycle
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_op              NREQ x 13-bit op bundle
//                       {BR_NOT,EQ,LTU,LTS,AND,OR,XOR,SHRA,SHR,SHL,SUB,ADD,IMM}
//   req_rs1/rs2/imm     NREQ x 32-bit operands
//   req_tag             NREQ x TAG_W opaque tag, returned unchanged
//   alu_op/rs1/rs2/imm  to the ALU, zero when S1 is empty
//   alu_rslt_valid/rslt from the ALU
//   rsp_valid/ready     response handshake
//   rsp_id/tag/data/err response payload
//   busy                S1 or S2 holds a request
module peak_rv32im_alu_arb #(
  parameter  int NREQ  = 2,
  parameter  int TAG_W = 5,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*13-1:0]    req_op,
  input  logic [NREQ*32-1:0]    req_rs1,
  input  logic [NREQ*32-1:0]    req_rs2,
  input  logic [NREQ*32-1:0]    req_imm,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  output logic [12:0]           alu_op,
  output logic [31:0]           alu_rs1,
  output logic [31:0]           alu_rs2,
  output logic [31:0]           alu_imm,
  input  logic                  alu_rslt_valid,
  input  logic [31:0]           alu_rslt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);

  // S1: operand stage
  logic             s1_v;
  logic [12:0]      s1_op;
  logic [31:0]      s1_rs1, s1_rs2, s1_imm;
  logic [IDW-1:0]   s1_id;
  logic [TAG_W-1:0] s1_tag;

  // S2: response stage
  logic             s2_v;
  logic [31:0]      s2_data;
  logic             s2_err;
  logic [IDW-1:0]   s2_id;
  logic [TAG_W-1:0] s2_tag;

  logic [IDW-1:0]   ptr;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_id;
  int               idx;

  logic             s2_adv, s1_adv, s1_free, accept;
  logic [3:0]       fn_cnt;
  logic             op_err;

  assign s2_adv  = !s2_v || rsp_ready;
  assign s1_adv  = s1_v && s2_adv;
  assign s1_free = !s1_v || s1_adv;

  // Round-robin search starting just after the last winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx[IDW-1:0];
      end
    end
  end

  // rst_n is folded in so nothing is acknowledged while reset is asserted.
  assign accept = gnt_found && s1_free && !flush && rst_n;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  // More than one of the eleven function bits (ADD..EQ) is a malformed op,
  // even if the ALU claims a valid result.
  always_comb begin
    fn_cnt = '0;
    for (int i = 1; i <= 11; i++) fn_cnt = fn_cnt + {3'b000, s1_op[i]};
  end
  assign op_err = !alu_rslt_valid || (fn_cnt > 4'd1);

  assign alu_op  = s1_v ? s1_op  : '0;
  assign alu_rs1 = s1_v ? s1_rs1 : '0;
  assign alu_rs2 = s1_v ? s1_rs2 : '0;
  assign alu_imm = s1_v ? s1_imm : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_op   <= '0;
      s1_rs1  <= '0;
      s1_rs2  <= '0;
      s1_imm  <= '0;
      s1_id   <= '0;
      s1_tag  <= '0;
      s2_v    <= 1'b0;
      s2_data <= '0;
      s2_err  <= 1'b0;
      s2_id   <= '0;
      s2_tag  <= '0;
      ptr     <= IDW'(NREQ - 1);
    end else if (flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (s2_adv) s2_v <= s1_v;
      if (s1_adv) begin
        s2_data <= alu_rslt;
        s2_err  <= op_err;
        s2_id   <= s1_id;
        s2_tag  <= s1_tag;
      end
      if (accept) begin
        s1_v   <= 1'b1;
        s1_op  <= req_op[int'(gnt_id)*13 +: 13];
        s1_rs1 <= req_rs1[int'(gnt_id)*32 +: 32];
        s1_rs2 <= req_rs2[int'(gnt_id)*32 +: 32];
        s1_imm <= req_imm[int'(gnt_id)*32 +: 32];
        s1_id  <= gnt_id;
        s1_tag <= req_tag[int'(gnt_id)*TAG_W +: TAG_W];
        ptr    <= gnt_id;
      end else if (s1_adv) begin
        s1_v <= 1'b0;
      end
    end
  end

  assign rsp_valid = s2_v;
  assign rsp_id    = s2_id;
  assign rsp_tag   = s2_tag;
  assign rsp_data  = s2_data;
  assign rsp_err   = s2_err;
  assign busy      = s1_v || s2_v;

endmodule
